// File: rtl/ttc_param_pkg9.sv
// rtl/ttc_param_pkg9.sv - register map, CTRL fields and IRQ layout for the timer block
package ttc_param_pkg9;

   localparam logic [7:0] CH_STRIDE       = 8'h10;
   localparam logic [3:0] OFF_CTRL        = 4'h0;
   localparam logic [3:0] OFF_INTERVAL    = 4'h4;
   localparam logic [3:0] OFF_MATCH       = 4'h8;
   localparam logic [3:0] OFF_COUNT       = 4'hC;
   localparam logic [7:0] ADDR_IRQ_STATUS = 8'hF0;
   localparam logic [7:0] ADDR_IRQ_EN     = 8'hF4;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE    = 1;
   localparam int CTRL_CLR     = 2;
   localparam int CTRL_PRE_LSB = 8;

   typedef enum logic {
      MODE_FREE     = 1'b0,
      MODE_INTERVAL = 1'b1
   } mode_e;

   function automatic logic [7:0] ch_base(input int ch);
      return 8'(ch) * CH_STRIDE;
   endfunction

   // each channel owns two adjacent IRQ bits: wrap/interval event, then match
   function automatic int wrap_bit(input int ch);
      return 2 * ch;
   endfunction

   function automatic int match_bit(input int ch);
      return 2 * ch + 1;
   endfunction

endpackage

// File: rtl/ttc_param_channel9.sv
// rtl/ttc_param_channel9.sv - one timer channel: prescaler, counter, compare, event pulses
module ttc_param_channel9
   import ttc_param_pkg9::*;
#(
   parameter int CNT_W = 16,
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  mode_e            mode,
   input  logic [PRE_W-1:0] pre,
   input  logic [CNT_W-1:0] interval,
   input  logic [CNT_W-1:0] match,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             wrap_evt,
   output logic             match_evt
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [PRE_W-1:0] PRE_ONE = 1;

   logic [PRE_W-1:0] pre_cnt;
   logic [CNT_W-1:0] next_count;
   logic             tick;

   // a clear in the same cycle swallows the tick, so no events can fire
   always_comb begin
      tick       = en && (pre_cnt == pre) && !clr;
      next_count = count + CNT_ONE;
      wrap_evt   = 1'b0;
      if (mode == MODE_INTERVAL && count == interval) begin
         next_count = '0;
         wrap_evt   = tick;
      end else if (mode == MODE_FREE && count == '1) begin
         wrap_evt   = tick;
      end
      match_evt = tick && (next_count == match);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
         count   <= '0;
      end else if (clr) begin
         pre_cnt <= '0;
         count   <= '0;
      end else if (en) begin
         pre_cnt <= (pre_cnt == pre) ? '0 : pre_cnt + PRE_ONE;
         if (tick) begin
            count <= next_count;
         end
      end
   end

endmodule

// File: rtl/ttc_param9.sv
// rtl/ttc_param9.sv - APB timer block: register decode, IRQ status/enable, channel array
module ttc_param9
   import ttc_param_pkg9::*;
#(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 16,
   parameter int PRE_W  = 8
) (
   input  logic              pclk9,
   input  logic              p_reset9,
   input  logic              psel9,
   input  logic              penable9,
   input  logic              pwrite9,
   input  logic [7:0]        paddr9,
   input  logic [31:0]       pwdata9,
   output logic [31:0]       prdata9,
   output logic [NUM_CH-1:0] interrupt9
);

   localparam int SW = 2 * NUM_CH;

   logic              wr;
   logic              rd;
   logic [3:0]        off;
   logic [NUM_CH-1:0] ch_hit;
   logic [NUM_CH-1:0] en_r;
   mode_e             mode_r     [NUM_CH];
   logic [PRE_W-1:0]  pre_r      [NUM_CH];
   logic [CNT_W-1:0]  interval_r [NUM_CH];
   logic [CNT_W-1:0]  match_r    [NUM_CH];
   logic [CNT_W-1:0]  count_w    [NUM_CH];
   logic [NUM_CH-1:0] clr_w;
   logic [NUM_CH-1:0] wrap_w;
   logic [NUM_CH-1:0] match_w;
   logic [SW-1:0]     set_w;
   logic [SW-1:0]     w1c;
   logic [SW-1:0]     status;
   logic [SW-1:0]     irq_en;
   logic              unused_pwdata;

   assign wr            = psel9 & penable9 & pwrite9;
   assign rd            = psel9 & ~pwrite9;
   assign off           = paddr9[3:0];
   assign w1c           = (wr && paddr9 == ADDR_IRQ_STATUS) ? pwdata9[SW-1:0] : '0;
   assign unused_pwdata = ^pwdata9;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [7:0] BASE = ch_base(g);

      assign ch_hit[g]            = (paddr9 & 8'hF0) == BASE;
      assign clr_w[g]             = wr && ch_hit[g] && off == OFF_CTRL && pwdata9[CTRL_CLR];
      assign set_w[wrap_bit(g)]   = wrap_w[g];
      assign set_w[match_bit(g)]  = match_w[g];

      ttc_param_channel9 #(.CNT_W(CNT_W), .PRE_W(PRE_W)) u_ch (
         .clk       (pclk9),
         .rst       (p_reset9),
         .en        (en_r[g]),
         .mode      (mode_r[g]),
         .pre       (pre_r[g]),
         .interval  (interval_r[g]),
         .match     (match_r[g]),
         .clr       (clr_w[g]),
         .count     (count_w[g]),
         .wrap_evt  (wrap_w[g]),
         .match_evt (match_w[g])
      );
   end

   always_ff @(posedge pclk9 or posedge p_reset9) begin
      if (p_reset9) begin
         en_r       <= '0;
         status     <= '0;
         irq_en     <= '0;
         interrupt9 <= '0;
         for (int n = 0; n < NUM_CH; n++) begin
            mode_r[n]     <= MODE_FREE;
            pre_r[n]      <= '0;
            interval_r[n] <= '0;
            match_r[n]    <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (wr && ch_hit[n]) begin
               case (off)
                  OFF_CTRL: begin
                     en_r[n]   <= pwdata9[CTRL_EN];
                     mode_r[n] <= mode_e'(pwdata9[CTRL_MODE]);
                     pre_r[n]  <= pwdata9[CTRL_PRE_LSB +: PRE_W];
                  end
                  OFF_INTERVAL: interval_r[n] <= pwdata9[CNT_W-1:0];
                  OFF_MATCH:    match_r[n]    <= pwdata9[CNT_W-1:0];
                  default: ;
               endcase
            end
            interrupt9[n] <= |(status[wrap_bit(n) +: 2] & irq_en[wrap_bit(n) +: 2]);
         end
         // new events win over a coincident write-1-to-clear
         status <= (status & ~w1c) | set_w;
         if (wr && paddr9 == ADDR_IRQ_EN) begin
            irq_en <= pwdata9[SW-1:0];
         end
      end
   end

   always_comb begin
      prdata9 = '0;
      if (rd) begin
         if (paddr9 == ADDR_IRQ_STATUS) begin
            prdata9[SW-1:0] = status;
         end else if (paddr9 == ADDR_IRQ_EN) begin
            prdata9[SW-1:0] = irq_en;
         end else begin
            for (int n = 0; n < NUM_CH; n++) begin
               if (ch_hit[n]) begin
                  case (off)
                     OFF_CTRL: begin
                        prdata9[CTRL_EN]                  = en_r[n];
                        prdata9[CTRL_MODE]                = mode_r[n];
                        prdata9[CTRL_PRE_LSB +: PRE_W]    = pre_r[n];
                     end
                     OFF_INTERVAL: prdata9[CNT_W-1:0] = interval_r[n];
                     OFF_MATCH:    prdata9[CNT_W-1:0] = match_r[n];
                     OFF_COUNT:    prdata9[CNT_W-1:0] = count_w[n];
                     default: ;
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ttc_param9.sv
// tb/tb_ttc_param9.sv - directed and randomized checks of ttc_param9 against a cycle model
module tb_ttc_param9;

   localparam int M = 65536;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata_a, prdata_b, last_rd;
   logic [2:0]  irq_a;
   logic [0:0]  irq_b;

   int n_checks = 0;
   int n_errors = 0;

   int m_count[3], m_pcnt[3], m_pre[3], m_interval[3], m_match[3];
   bit m_en[3], m_mode[3];
   int m_status, m_irq_en, m_irq;

   always #5 clk = ~clk;

   ttc_param9 #(.NUM_CH(3), .CNT_W(16), .PRE_W(8)) dut_a (
      .pclk9(clk), .p_reset9(rst), .psel9(psel_a), .penable9(penable), .pwrite9(pwrite),
      .paddr9(paddr), .pwdata9(pwdata), .prdata9(prdata_a), .interrupt9(irq_a));

   ttc_param9 #(.NUM_CH(1), .CNT_W(16), .PRE_W(8)) dut_b (
      .pclk9(clk), .p_reset9(rst), .psel9(psel_b), .penable9(penable), .pwrite9(pwrite),
      .paddr9(paddr), .pwdata9(pwdata), .prdata9(prdata_b), .interrupt9(irq_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int n = 0; n < 3; n++) begin
         m_count[n] = 0; m_pcnt[n] = 0; m_pre[n] = 0; m_interval[n] = 0;
         m_match[n] = 0; m_en[n] = 0; m_mode[n] = 0;
      end
      m_status = 0; m_irq_en = 0; m_irq = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [7:0] a);
      int ch;
      int o;
      ch = int'(a[7:4]);
      o  = int'(a[3:0]);
      if (a == 8'hF0) return m_status;
      if (a == 8'hF4) return m_irq_en;
      if (ch >= 3) return 0;
      case (o)
         0:  return m_en[ch] | (m_mode[ch] << 1) | (m_pre[ch] << 8);
         4:  return m_interval[ch];
         8:  return m_match[ch];
         12: return m_count[ch];
         default: return 0;
      endcase
   endfunction

   // one clock edge of the reference: everything derived from the pre-edge view
   task automatic step();
      int nc[3], npc[3], npre[3], nint[3], nmat[3];
      bit nen[3], nmode[3];
      bit wr, clr, tk, wev;
      int a, cand, set, w1c, nirq, nst, nie;
      logic [31:0] d;
      wr = psel_a && penable && pwrite;
      a = int'(paddr);
      d = pwdata;
      set = 0;
      for (int n = 0; n < 3; n++) begin
         clr = wr && a == n * 16 && d[2];
         tk  = m_en[n] && m_pcnt[n] == m_pre[n] && !clr;
         if (m_mode[n] && m_count[n] == m_interval[n]) begin
            cand = 0; wev = 1;
         end else begin
            cand = (m_count[n] + 1) % M; wev = !m_mode[n] && cand == 0;
         end
         if (tk && wev) set |= 1 << (2 * n);
         if (tk && cand == m_match[n]) set |= 1 << (2 * n + 1);
         nc[n]  = clr ? 0 : (tk ? cand : m_count[n]);
         npc[n] = clr ? 0 : (!m_en[n] ? m_pcnt[n] :
                            (m_pcnt[n] == m_pre[n] ? 0 : (m_pcnt[n] + 1) % 256));
         nen[n] = m_en[n]; nmode[n] = m_mode[n]; npre[n] = m_pre[n];
         nint[n] = m_interval[n]; nmat[n] = m_match[n];
         if (wr && a == n * 16) begin
            nen[n] = d[0]; nmode[n] = d[1]; npre[n] = int'((d >> 8) & 32'hFF);
         end
         if (wr && a == n * 16 + 4) nint[n] = int'(d & 32'hFFFF);
         if (wr && a == n * 16 + 8) nmat[n] = int'(d & 32'hFFFF);
      end
      w1c  = (wr && a == 240) ? int'(d & 32'h3F) : 0;
      nst  = (m_status & ~w1c) | set;
      nie  = (wr && a == 244) ? int'(d & 32'h3F) : m_irq_en;
      nirq = 0;
      for (int n = 0; n < 3; n++)
         if (((m_status & m_irq_en) >> (2 * n)) & 3) nirq |= 1 << n;
      @(posedge clk);
      if (rst) begin
         m_reset();
      end else begin
         for (int n = 0; n < 3; n++) begin
            m_count[n] = nc[n]; m_pcnt[n] = npc[n]; m_en[n] = nen[n]; m_mode[n] = nmode[n];
            m_pre[n] = npre[n]; m_interval[n] = nint[n]; m_match[n] = nmat[n];
         end
         m_status = nst; m_irq_en = nie; m_irq = nirq;
      end
      #1;
      chk("irq_model", {29'b0, irq_a}, m_irq);
   endtask

   task automatic wr(input bit tgt_b, input logic [7:0] a, input logic [31:0] d);
      psel_a = !tgt_b; psel_b = tgt_b; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
      step();
      penable = 1'b1;
      step();
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic rd_chk(input bit tgt_b, input logic [7:0] a, input logic [31:0] exp,
                         input string tag);
      psel_a = !tgt_b; psel_b = tgt_b; pwrite = 1'b0; penable = 1'b0; paddr = a;
      #1;
      last_rd = tgt_b ? prdata_b : prdata_a;
      chk(tag, last_rd, exp);
      psel_a = 1'b0; psel_b = 1'b0;
   endtask

   initial begin
      int guard;
      logic [7:0] ra;
      m_reset();

      // reset state and reset asserted mid-count
      repeat (2) step();
      rst = 1'b0;
      step();
      rd_chk(0, 8'h00, 0, "rst_ctrl");
      rd_chk(0, 8'h0C, 0, "rst_count");
      rd_chk(0, 8'hF0, 0, "rst_status");
      step();
      rd_chk(0, 8'hF4, 0, "rst_irq_en");
      chk("rst_irq", {29'b0, irq_a}, 0);
      wr(0, 8'h04, 0);
      wr(0, 8'hF4, 1);
      wr(0, 8'h00, 32'h3);
      repeat (3) step();
      chk("pre_rst_irq", {29'b0, irq_a}, 1);
      rst = 1'b1;
      m_reset();
      #1;
      chk("mid_rst_irq", {29'b0, irq_a}, 0);
      rd_chk(0, 8'hF0, 0, "mid_rst_status");
      rd_chk(0, 8'h00, 0, "mid_rst_ctrl");
      step();
      rst = 1'b0;
      step();

      // ch0 interval mode, PRE=3, INTERVAL=4, MATCH=2, only wrap IRQ enabled
      wr(0, 8'h04, 4);
      wr(0, 8'h08, 2);
      wr(0, 8'hF4, 1);
      wr(0, 8'h00, 32'h307);
      for (int k = 1; k <= 21; k++) begin
         step();
         rd_chk(0, 8'h0C, (k / 4) % 5, "t2_count");
         rd_chk(0, 8'hF0, ((k >= 20) ? 1 : 0) | ((k >= 8) ? 2 : 0), "t2_status");
         chk("t2_irq", {29'b0, irq_a}, (k >= 21) ? 1 : 0);
      end
      wr(0, 8'h00, 32'h4);
      wr(0, 8'hF0, 32'hFFFF_FFFF);
      wr(0, 8'hF4, 0);

      // ch1 free-run to the top of the range: match then wrap
      wr(0, 8'h18, 32'hFFFF);
      wr(0, 8'hF4, 32'hC);
      wr(0, 8'h10, 32'h5);
      repeat (65534) step();
      rd_chk(0, 8'hF0, 0, "t3_before");
      step();
      rd_chk(0, 8'h1C, 32'hFFFF, "t3_count_max");
      rd_chk(0, 8'hF0, 32'h8, "t3_match");
      step();
      rd_chk(0, 8'h1C, 0, "t3_count_wrap");
      rd_chk(0, 8'hF0, 32'hC, "t3_wrap");
      wr(0, 8'hF0, 32'hC);
      rd_chk(0, 8'hF0, 0, "t3_w1c");
      wr(0, 8'h10, 32'h4);
      wr(0, 8'hF4, 0);

      // W1C of bit0 landing on the same edge as a wrap event
      wr(0, 8'h04, 3);
      wr(0, 8'h00, 32'h7);
      psel_a = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'hF0; pwdata = 32'h1;
      step();
      guard = 0;
      while (!(m_en[0] && m_mode[0] && m_pcnt[0] == m_pre[0] && m_count[0] == m_interval[0])
             && guard < 10) begin
         step();
         guard++;
      end
      chk("t4_sync", guard < 10, 1);
      penable = 1'b1;
      step();
      psel_a = 1'b0; penable = 1'b0; pwrite = 1'b0;
      rd_chk(0, 8'hF0, m_read(8'hF0), "t4_status");
      chk("t4_keep", {31'b0, last_rd[0]}, 1);
      wr(0, 8'h00, 32'h4);
      wr(0, 8'hF0, 32'hFFFF_FFFF);

      // CLR on an edge that carries a tick which would have matched
      wr(0, 8'h28, 4);
      wr(0, 8'h20, 32'h5);
      step();
      step();
      wr(0, 8'h20, 32'h5);
      rd_chk(0, 8'h2C, 0, "t5_count");
      rd_chk(0, 8'hF0, 0, "t5_status");
      wr(0, 8'h20, 32'h4);

      // randomized traffic against the model
      for (int it = 0; it < 400; it++) begin
         int ch;
         ch = $urandom_range(0, 3);
         case ($urandom_range(0, 9))
            0, 1: wr(0, 8'(ch * 16), $urandom & 32'h0307);
            2:    wr(0, 8'(ch * 16 + 4), $urandom_range(0, 12));
            3:    wr(0, 8'(ch * 16 + 4 * $urandom_range(2, 3)), $urandom_range(0, 12));
            4:    wr(0, 8'hF0, $urandom);
            5:    wr(0, 8'hF4, $urandom);
            6, 7: begin
               case ($urandom_range(0, 4))
                  0:       ra = 8'hF0;
                  1:       ra = 8'hF4;
                  2:       ra = 8'($urandom);
                  default: ra = 8'(ch * 16 + 4 * $urandom_range(0, 3));
               endcase
               rd_chk(0, ra, m_read(ra), "rand_read");
               step();
            end
            default: repeat ($urandom_range(1, 5)) step();
         endcase
      end

      // single-channel build: everything above channel 0 is unmapped
      wr(1, 8'h00, 32'h305);
      wr(1, 8'hF4, 32'hFF);
      for (int a = 8'h10; a <= 8'hEC; a += 4) wr(1, 8'(a), 32'hFFFF_FFFF);
      rd_chk(1, 8'h00, 32'h301, "b_ctrl");
      rd_chk(1, 8'hF4, 32'h3, "b_irq_en");
      step();
      rd_chk(1, 8'h04, 0, "b_interval");
      for (int a = 8'h10; a <= 8'hEC; a += 4) begin
         rd_chk(1, 8'(a), 0, "b_unmapped");
         step();
      end
      chk("b_irq", {31'b0, irq_b}, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
